// File: rtl/force_accum_ctrl_pkg.sv
// Shared constants and types for the per-particle force accumulator.
package force_accum_ctrl_pkg;

    localparam int unsigned DEF_ID_WIDTH    = 4;
    localparam int unsigned DEF_ADD_LATENCY = 2;

    // +0.0 in IEEE-754 single precision.
    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    // RUN: accepting samples. DRAIN: waiting for in-flight sums to land.
    // CLR: zeroing one accumulator entry per cycle.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLR   = 2'd2
    } state_e;

    // One stage for the operand register plus one per adder pipeline stage.
    function automatic int unsigned tracker_depth(input int unsigned add_latency);
        return add_latency + 1;
    endfunction

endpackage

// File: rtl/accum_hazard_tracker.sv
// In-flight sum tracker: shift register of {valid, id} that follows each
// accepted sample through the adder, flags read-after-write hazards on the
// probed id and presents the entry that is due for writeback.
module accum_hazard_tracker
    import force_accum_ctrl_pkg::*;
#(
    parameter int unsigned ID_WIDTH = DEF_ID_WIDTH,
    parameter int unsigned DEPTH    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_valid_i,
    input  logic [ID_WIDTH-1:0] push_id_i,
    input  logic [ID_WIDTH-1:0] probe_id_i,
    output logic                hit_o,
    output logic                empty_o,
    output logic                wb_valid_o,
    output logic [ID_WIDTH-1:0] wb_id_o
);

    logic [DEPTH-1:0]    valid_q;
    logic [ID_WIDTH-1:0] id_q [DEPTH];

    // Advance every in-flight entry by one stage; a bubble enters when nothing is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i] <= '0;
            end
        end else begin
            valid_q <= {valid_q[DEPTH-2:0], push_valid_i};
            id_q[0] <= push_id_i;
            for (int i = 1; i < DEPTH; i++) begin
                id_q[i] <= id_q[i-1];
            end
        end
    end

    // Parallel compare of the probed id against every valid stage.
    always_comb begin
        hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (id_q[i] == probe_id_i)) begin
                hit_o = 1'b1;
            end
        end
    end

    assign empty_o    = ~|valid_q;
    assign wb_valid_o = valid_q[DEPTH-1];
    assign wb_id_o    = id_q[DEPTH-1];

endmodule

// File: rtl/force_accum_ctrl.sv
// Per-particle force accumulator: streams (id, force) pairs into an external
// FP32 adder, writes sums back into a register array, stalls on RAW hazards,
// and supports a drain-then-zero timestep clear plus random readout.
module force_accum_ctrl
    import force_accum_ctrl_pkg::*;
#(
    parameter int unsigned ID_WIDTH    = DEF_ID_WIDTH,
    parameter int unsigned ADD_LATENCY = DEF_ADD_LATENCY
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ID_WIDTH-1:0] in_id,
    input  logic [31:0]         in_force,
    output logic [31:0]         add_ax,
    output logic [31:0]         add_ay,
    input  logic [31:0]         add_result,
    input  logic                clear,
    output logic                busy,
    input  logic                rd_en,
    input  logic [ID_WIDTH-1:0] rd_id,
    output logic                rd_valid,
    output logic [31:0]         rd_data
);

    localparam int unsigned         NUM_ENTRIES = 2 ** ID_WIDTH;
    localparam int unsigned         TRK_DEPTH   = tracker_depth(ADD_LATENCY);
    localparam logic [ID_WIDTH-1:0] CNT_LAST    = ID_WIDTH'(NUM_ENTRIES - 1);

    state_e              state_q, state_d;
    logic [ID_WIDTH-1:0] cnt_q, cnt_d;
    logic                clr_we;

    logic [31:0]         acc_q [NUM_ENTRIES];
    logic [31:0]         ax_q, ay_q;
    logic                rd_valid_q;
    logic [31:0]         rd_data_q;

    logic                accept;
    logic                trk_hit;
    logic                trk_empty;
    logic                wb_valid;
    logic [ID_WIDTH-1:0] wb_id;

    // The hazard check looks at in_id only, so in_ready never depends on in_valid.
    assign in_ready = (state_q == RUN) && !trk_hit;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != RUN);

    accum_hazard_tracker #(
        .ID_WIDTH (ID_WIDTH),
        .DEPTH    (TRK_DEPTH)
    ) u_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (accept),
        .push_id_i    (in_id),
        .probe_id_i   (in_id),
        .hit_o        (trk_hit),
        .empty_o      (trk_empty),
        .wb_valid_o   (wb_valid),
        .wb_id_o      (wb_id)
    );

    // Next-state logic: clear is honoured only in RUN; DRAIN lets in-flight sums land first.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (clear) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (trk_empty) begin
                    state_d = CLR;
                    cnt_d   = '0;
                end
            end
            CLR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // FSM state and clear-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Adder operands: capture on accept, otherwise hold the previous pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ax_q <= FP32_ZERO;
            ay_q <= FP32_ZERO;
        end else if (accept) begin
            ax_q <= acc_q[in_id];
            ay_q <= in_force;
        end
    end

    // Accumulator array: adder writeback and one-entry-per-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is reset explicitly because a reset must leave every accumulator at +0.0.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                acc_q[i] <= FP32_ZERO;
            end
        end else begin
            if (wb_valid) begin
                acc_q[wb_id] <= add_result;
            end
            if (clr_we) begin
                acc_q[cnt_q] <= FP32_ZERO;
            end
        end
    end

    // Readout: registered, sampling the array before any same-edge write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= FP32_ZERO;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= acc_q[rd_id];
            end
        end
    end

    assign add_ax   = ax_q;
    assign add_ay   = ay_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule
